// File: rtl/boton_multicanal_pkg.sv
// rtl/boton_multicanal_pkg.sv - shared board timing constants and per-channel press states
package boton_multicanal_pkg;

  localparam int CLK_FREQ_HZ     = 50_000_000;
  localparam int ANTIREBOTE_10MS = 500_000;
  localparam int LONG_1S         = 50_000_000;

  // Level is implied by the state: IDLE is released, PRESSED/HELD are pressed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_t;

endpackage

// File: rtl/boton_canal.sv
// rtl/boton_canal.sv - one button channel: 2-FF sync, debounce, short/long press classifier
module boton_canal
  import boton_multicanal_pkg::*;
#(
  parameter int TIME_ANTIREBOTE = 10,
  parameter int MIN_TIME        = 500
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_long,
  output logic o_hold
);

  localparam int DB_W   = $clog2(TIME_ANTIREBOTE + 1);
  localparam int HOLD_W = $clog2(MIN_TIME + 1);

  logic              r_sync1, r_sync2;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  btn_state_t        r_state;
  logic              r_press, r_release, r_short, r_long;

  logic              w_level, w_differ, w_flip, w_reach;
  logic [DB_W-1:0]   w_db_cnt_nxt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  btn_state_t        w_state_nxt;
  logic              w_press_nxt, w_release_nxt, w_short_nxt, w_long_nxt;

  assign w_level  = (r_state != ST_IDLE);
  assign w_differ = (r_sync2 != w_level);
  assign w_flip   = w_differ && (r_db_cnt == DB_W'(TIME_ANTIREBOTE - 1));
  assign w_reach  = (r_hold_cnt == HOLD_W'(MIN_TIME - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_press_nxt    = 1'b0;
    w_release_nxt  = 1'b0;
    w_short_nxt    = 1'b0;
    w_long_nxt     = 1'b0;
    w_db_cnt_nxt   = (w_differ && !w_flip) ? r_db_cnt + DB_W'(1) : '0;
    case (r_state)
      ST_IDLE: begin
        if (w_flip) begin
          w_state_nxt = ST_PRESSED;
          w_press_nxt = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (w_flip) begin
          w_state_nxt   = ST_IDLE;
          w_release_nxt = 1'b1;
          w_short_nxt   = 1'b1;
        end else if (w_reach) begin
          w_state_nxt = ST_HELD;
          w_long_nxt  = 1'b1;
        end
      end
      ST_HELD: begin
        if (w_flip) begin
          w_state_nxt   = ST_IDLE;
          w_release_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Count starts from zero on the press edge and saturates once the long press is reached.
    if (r_state == ST_IDLE || w_state_nxt == ST_IDLE)
      w_hold_cnt_nxt = '0;
    else if (r_hold_cnt != HOLD_W'(MIN_TIME))
      w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
    else
      w_hold_cnt_nxt = r_hold_cnt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_state    <= ST_IDLE;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_db_cnt   <= w_db_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_state    <= w_state_nxt;
      r_press    <= w_press_nxt;
      r_release  <= w_release_nxt;
      r_short    <= w_short_nxt;
      r_long     <= w_long_nxt;
    end
  end

  assign o_level   = w_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_short   = r_short;
  assign o_long    = r_long;
  assign o_hold    = (r_state == ST_HELD);

endmodule

// File: rtl/boton_multicanal.sv
// rtl/boton_multicanal.sv - N-channel push-button front end with short/long press events
module boton_multicanal
  import boton_multicanal_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int TIME_ANTIREBOTE = 10,
  parameter int MIN_TIME        = 500,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_short,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_hold
);

  logic [N_BTN-1:0] w_raw;

  assign w_raw = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  for (genvar g = 0; g < N_BTN; g++) begin : g_canal
    boton_canal #(
      .TIME_ANTIREBOTE(TIME_ANTIREBOTE),
      .MIN_TIME       (MIN_TIME)
    ) u_canal (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_btn    (w_raw[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g]),
      .o_short  (btn_short[g]),
      .o_long   (btn_long[g]),
      .o_hold   (btn_hold[g])
    );
  end

endmodule

// File: tb/tb_boton_multicanal.sv
// tb/tb_boton_multicanal.sv - scoreboard bench for boton_multicanal, active-high and active-low instances
module tb_boton_multicanal;

  localparam int T   = 10;
  localparam int M   = 500;
  localparam int LAT = T + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_al = 1'b1;
  logic [1:0] btn = 2'b11;
  logic [1:0] btn_al = 2'b11;

  logic [1:0] lvl0, pr0, rl0, sh0, lg0, hd0;
  logic [1:0] lvl1, pr1, rl1, sh1, lg1, hd1;

  boton_multicanal #(.N_BTN(2), .TIME_ANTIREBOTE(T), .MIN_TIME(M), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_level(lvl0), .btn_press(pr0), .btn_release(rl0),
    .btn_short(sh0), .btn_long(lg0), .btn_hold(hd0)
  );

  boton_multicanal #(.N_BTN(2), .TIME_ANTIREBOTE(T), .MIN_TIME(M), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst_al), .btn_in(btn_al),
    .btn_level(lvl1), .btn_press(pr1), .btn_release(rl1),
    .btn_short(sh1), .btn_long(lg1), .btn_hold(hd1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // kind: 0 press, 1 release, 2 short, 3 long
  function automatic int evt(input int c, input int inst, input int ch, input int kind);
    return c * 64 + inst * 8 + ch * 4 + kind;
  endfunction

  task automatic push(input int c, input int inst, input int ch, input int kind);
    exp_q.push_back(evt(c, inst, ch, kind));
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input int c);
    goto(c);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [7:0] ev [2];
    ev[0] = {lg0, sh0, rl0, pr0};
    ev[1] = {lg1, sh1, rl1, pr1};
    for (int inst = 0; inst < 2; inst++)
      for (int ch = 0; ch < 2; ch++)
        for (int kind = 0; kind < 4; kind++)
          if (ev[inst][kind*2+ch]) begin
            if (exp_q.size() == 0) chk("evt_extra", evt(cyc, inst, ch, kind), -1);
            else chk("evt", evt(cyc, inst, ch, kind), exp_q.pop_front());
          end
  end

  initial begin
    int s, l, p, d;

    // reset held with both buttons pressed
    for (int k = 1; k <= 5; k++) begin
      sample(k * 10);
      chk("rst_out0", int'({lvl0, pr0, rl0, sh0, lg0, hd0}), 0);
    end
    chk("rst_out1", int'({lvl1, pr1, rl1, sh1, lg1, hd1}), 0);
    goto(52);
    btn = 2'b00;
    goto(55);
    rst = 1'b0;
    rst_al = 1'b0;
    sample(85);
    chk("idle_lvl", int'({lvl0, lvl1}), 0);

    // bouncing ch0, settles high
    s = 90;
    for (int i = 0; i < 13; i++) begin
      goto(s + 3 * i);
      btn[0] = ~btn[0];
    end
    l = s + 36;
    push(l + LAT, 0, 0, 0);
    sample(l + LAT - 1);
    chk("bounce_lvl_pre", int'(lvl0), 0);
    sample(l + LAT);
    chk("bounce_lvl_post", int'(lvl0), 1);
    goto(l + 100);
    btn[0] = 1'b0;
    push(l + 100 + LAT, 0, 0, 1);
    push(l + 100 + LAT, 0, 0, 2);
    sample(l + 100 + LAT);
    chk("bounce_rel_lvl", int'(lvl0), 0);

    // short press ch0
    s = 300;
    goto(s);
    btn[0] = 1'b1;
    push(s + LAT, 0, 0, 0);
    sample(s + 150);
    chk("short_hold", int'(hd0), 0);
    chk("short_lvl", int'(lvl0), 1);
    goto(s + 200);
    btn[0] = 1'b0;
    push(s + 200 + LAT, 0, 0, 1);
    push(s + 200 + LAT, 0, 0, 2);

    // long press ch1
    s = 600;
    goto(s);
    btn[1] = 1'b1;
    push(s + LAT, 0, 1, 0);
    push(s + LAT + M, 0, 1, 3);
    sample(s + LAT + M - 1);
    chk("long_hold_pre", int'(hd0), 0);
    sample(s + LAT + M);
    chk("long_hold_set", int'(hd0), 2);
    goto(s + 600);
    btn[1] = 1'b0;
    push(s + 600 + LAT, 0, 1, 1);
    sample(s + 600 + LAT - 1);
    chk("long_hold_keep", int'(hd0), 2);
    sample(s + 600 + LAT);
    chk("long_rel_hold", int'(hd0), 0);
    chk("long_rel_lvl", int'(lvl0), 0);

    // both channels pressed together
    s = 1300;
    goto(s);
    btn = 2'b11;
    push(s + LAT, 0, 0, 0);
    push(s + LAT, 0, 1, 0);
    goto(s + 200);
    btn[0] = 1'b0;
    push(s + 200 + LAT, 0, 0, 1);
    push(s + 200 + LAT, 0, 0, 2);
    push(s + LAT + M, 0, 1, 3);
    sample(s + LAT + M);
    chk("dual_hold", int'(hd0), 2);
    goto(s + 600);
    btn[1] = 1'b0;
    push(s + 600 + LAT, 0, 1, 1);
    sample(s + 600 + LAT + 5);
    chk("dual_end_lvl", int'(lvl0), 0);

    // active-low instance, reset mid-press
    s = 2000;
    goto(s);
    btn_al[0] = 1'b0;
    p = s + LAT;
    push(p, 1, 0, 0);
    sample(p + 1);
    chk("al_lvl", int'(lvl1), 1);
    goto(p + 300);
    rst_al = 1'b1;
    sample(p + 300);
    chk("al_rst_clear", int'({lvl1, hd1}), 0);
    goto(p + 305);
    rst_al = 1'b0;
    d = p + 305;
    push(d + LAT, 1, 0, 0);
    push(d + LAT + M, 1, 0, 3);
    sample(d + LAT - 1);
    chk("al_repress_pre", int'(lvl1), 0);
    sample(d + LAT);
    chk("al_repress_post", int'(lvl1), 1);
    sample(d + LAT + M);
    chk("al_hold", int'(hd1), 1);
    goto(d + 600);
    btn_al[0] = 1'b1;
    push(d + 600 + LAT, 1, 0, 1);
    sample(d + 600 + LAT + 20);
    chk("al_end", int'({lvl1, hd1}), 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
